// File: rtl/nes_bus_pkg.sv
// Shared types and constants for the NES CPU-side bus decoder.
package nes_bus_pkg;

  typedef enum logic [1:0] {
    RGN_RAM,
    RGN_PAD,
    RGN_PRG,
    RGN_NONE
  } region_e;

  localparam int unsigned DEF_RAM_TOP  = 32'h0000_1FFF;
  localparam int unsigned DEF_PRG_BASE = 32'h0000_8000;
  localparam int unsigned DEF_PAD_BASE = 32'h0000_4016;

  // Pad read byte: bit 0 carries the serial data, bits 4:1 read as zero and
  // the upper bits come from the open-bus latch.
  localparam int PAD_D_BIT    = 0;
  localparam int PAD_ZERO_LSB = 1;
  localparam int PAD_OB_LSB   = 5;

endpackage

// File: rtl/nes_cpu_bus_if.sv
// CPU data port, memory data/address and controller signals of the bus decoder.
interface nes_cpu_bus_if #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 8,
  parameter int RAM_AW   = 11,
  parameter int NUM_PADS = 2,
  parameter int PAD_BITS = 8
);
  logic [ADDR_W-1:0]            ADDR;
  logic                         CPU_RW;
  logic                         CPU_EN;
  logic [DATA_W-1:0]            CPU_DO;
  logic [DATA_W-1:0]            SYSRAM_Q;
  logic [DATA_W-1:0]            PRGROM_Q;
  logic [NUM_PADS*PAD_BITS-1:0] PAD_STATE;
  logic [DATA_W-1:0]            BUS_OUT;
  logic [RAM_AW-1:0]            SYSRAM_ADDR;
  logic                         SYSRAM_WE;
  logic [ADDR_W-2:0]            PRGROM_ADDR;
  logic                         PAD_STROBE;
  logic [DATA_W-1:0]            OPEN_BUS;

  modport master (
    output ADDR, CPU_RW, CPU_EN, CPU_DO, SYSRAM_Q, PRGROM_Q, PAD_STATE,
    input  BUS_OUT, SYSRAM_ADDR, SYSRAM_WE, PRGROM_ADDR, PAD_STROBE, OPEN_BUS
  );

  modport slave (
    input  ADDR, CPU_RW, CPU_EN, CPU_DO, SYSRAM_Q, PRGROM_Q, PAD_STATE,
    output BUS_OUT, SYSRAM_ADDR, SYSRAM_WE, PRGROM_ADDR, PAD_STROBE, OPEN_BUS
  );
endinterface

// File: rtl/nes_pad_shift.sv
// One controller port: reloads from live buttons while strobed, otherwise
// shifts right on each completed read, back-filling with 1s.
module nes_pad_shift #(
  parameter int PAD_BITS = 8
) (
  input  logic                CLK,
  input  logic                RESET_N,
  input  logic                strobe,
  input  logic [PAD_BITS-1:0] live,
  input  logic                shift_en,
  output logic                rd_bit
);

  logic [PAD_BITS-1:0] sr_q;
  logic [PAD_BITS-1:0] sr_d;
  logic [PAD_BITS:0]   sr_ext;

  always_comb begin
    sr_ext = {1'b1, sr_q};
    sr_d   = sr_q;
    if (strobe) begin
      sr_d = live;
    end else if (shift_en) begin
      sr_d = sr_ext[PAD_BITS:1];
    end
  end

  assign rd_bit = strobe ? live[0] : sr_q[0];

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sr_q <= '1;
    end else begin
      sr_q <= sr_d;
    end
  end

endmodule

// File: rtl/nes_cpu_bus.sv
// CPU-side bus decoder: mirrored RAM, PRG ROM, serial controller ports and
// the open-bus latch that answers unmapped reads.
module nes_cpu_bus
  import nes_bus_pkg::*;
#(
  parameter int          ADDR_W   = 16,
  parameter int          DATA_W   = 8,
  parameter int          RAM_AW   = 11,
  parameter int unsigned RAM_TOP  = DEF_RAM_TOP,
  parameter int unsigned PRG_BASE = DEF_PRG_BASE,
  parameter int unsigned PAD_BASE = DEF_PAD_BASE,
  parameter int          NUM_PADS = 2,
  parameter int          PAD_BITS = 8
) (
  input logic          CLK,
  input logic          RESET_N,
  nes_cpu_bus_if.slave bus
);

  localparam int unsigned PAD_END = PAD_BASE + NUM_PADS;
  localparam int          PIDX_W  = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1;

  region_e             region;
  logic [31:0]         addr32;
  logic [31:0]         pad_off;
  logic [31:0]         prg_off;
  logic [PIDX_W-1:0]   pad_idx;
  logic                rd_en;
  logic                wr_en;
  logic                pad_d;
  logic [DATA_W-1:0]   pad_word;
  logic [DATA_W-1:0]   bus_out;
  logic [NUM_PADS-1:0] shift_en;
  logic [NUM_PADS-1:0] rd_bits;

  logic                strobe_q;
  logic                strobe_d;
  logic [DATA_W-1:0]   open_bus_q;
  logic [DATA_W-1:0]   open_bus_d;

  always_comb begin
    addr32  = 32'(bus.ADDR);
    pad_off = addr32 - PAD_BASE;
    prg_off = addr32 - PRG_BASE;
    pad_idx = pad_off[PIDX_W-1:0];
    rd_en   = bus.CPU_EN & bus.CPU_RW;
    wr_en   = bus.CPU_EN & ~bus.CPU_RW;

    if (addr32 <= RAM_TOP) begin
      region = RGN_RAM;
    end else if (addr32 >= PAD_BASE && addr32 < PAD_END) begin
      region = RGN_PAD;
    end else if (addr32 >= PRG_BASE) begin
      region = RGN_PRG;
    end else begin
      region = RGN_NONE;
    end

    pad_d    = 1'b1;
    shift_en = '0;
    for (int i = 0; i < NUM_PADS; i++) begin
      if (pad_idx == PIDX_W'(i)) begin
        pad_d       = rd_bits[i];
        shift_en[i] = rd_en & (region == RGN_PAD) & ~strobe_q;
      end
    end

    for (int b = 0; b < DATA_W; b++) begin
      if (b == PAD_D_BIT) begin
        pad_word[b] = pad_d;
      end else if (b >= PAD_ZERO_LSB && b < PAD_OB_LSB) begin
        pad_word[b] = 1'b0;
      end else begin
        pad_word[b] = open_bus_q[b];
      end
    end

    bus_out = bus.CPU_DO;
    if (rd_en) begin
      case (region)
        RGN_RAM: bus_out = bus.SYSRAM_Q;
        RGN_PAD: bus_out = pad_word;
        RGN_PRG: bus_out = bus.PRGROM_Q;
        default: bus_out = open_bus_q;
      endcase
    end

    // Only the strobe port itself is writable; the next address belongs to the APU.
    strobe_d = strobe_q;
    if (wr_en && addr32 == PAD_BASE) begin
      strobe_d = bus.CPU_DO[0];
    end

    open_bus_d = bus.CPU_EN ? bus_out : open_bus_q;
  end

  for (genvar i = 0; i < NUM_PADS; i++) begin : g_pad
    nes_pad_shift #(
      .PAD_BITS(PAD_BITS)
    ) u_pad (
      .CLK     (CLK),
      .RESET_N (RESET_N),
      .strobe  (strobe_q),
      .live    (bus.PAD_STATE[i*PAD_BITS +: PAD_BITS]),
      .shift_en(shift_en[i]),
      .rd_bit  (rd_bits[i])
    );
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      strobe_q   <= 1'b0;
      open_bus_q <= '0;
    end else begin
      strobe_q   <= strobe_d;
      open_bus_q <= open_bus_d;
    end
  end

  assign bus.BUS_OUT     = bus_out;
  assign bus.SYSRAM_ADDR = bus.ADDR[RAM_AW-1:0];
  assign bus.SYSRAM_WE   = wr_en & (region == RGN_RAM);
  assign bus.PRGROM_ADDR = prg_off[ADDR_W-2:0];
  assign bus.PAD_STROBE  = strobe_q;
  assign bus.OPEN_BUS    = open_bus_q;

endmodule

// File: doc/nes_cpu_bus.md
# nes_cpu_bus

Parametrised CPU-side bus decoder for the NES core, sitting between the 6502 data port and the system RAM, PRG ROM and controller ports. It maps RAM with mirroring and decodes PRG ROM. It implements the serial controller-port protocol (strobe latch plus per-pad shift registers), and it holds an open-bus latch that supplies data for unmapped reads. Pad count, pad report width, RAM size and region bases are parameters.

## Interface
- ADDR_W, 16, CPU address width
- DATA_W, 8, data width
- RAM_AW, 11, system RAM address width (2 KiB, mirrored up to RAM_TOP)
- RAM_TOP, 16'h1FFF, last address of the mirrored RAM region
- PRG_BASE, 16'h8000, first PRG ROM address; region runs to the top of the address space
- PAD_BASE, 16'h4016, address of pad 0; pad i sits at PAD_BASE+i
- NUM_PADS, 2, controller ports, 1..4
- PAD_BITS, 8, buttons per pad report, 1..32

Ports:
- CLK  in  1  system clock
- RESET_N  in  1  asynchronous active-low reset
- ADDR  in  ADDR_W  CPU address
- CPU_RW  in  1  1 = read, 0 = write
- CPU_EN  in  1  bus cycle completes this cycle
- CPU_DO  in  DATA_W  CPU write data
- SYSRAM_Q  in  DATA_W  RAM read data
- PRGROM_Q  in  DATA_W  ROM read data
- PAD_STATE  in  NUM_PADS*PAD_BITS  live button state; pad i occupies bits [i*PAD_BITS +: PAD_BITS], bit 0 = A
- BUS_OUT  out  DATA_W  data returned to the CPU
- SYSRAM_ADDR  out  RAM_AW  ADDR[RAM_AW-1:0]
- SYSRAM_WE  out  1  RAM write enable
- PRGROM_ADDR  out  ADDR_W-1  ADDR - PRG_BASE
- PAD_STROBE  out  1  current strobe latch value
- OPEN_BUS  out  DATA_W  current open-bus latch value

## Operation
- Regions are decoded from ADDR every cycle with priority RAM (ADDR<=RAM_TOP), PAD (PAD_BASE<=ADDR<PAD_BASE+NUM_PADS), PRG (ADDR>=PRG_BASE). Everything else is unmapped.
- RAM:
  - SYSRAM_ADDR drops the upper address bits, which produces mirroring ($0800 aliases $0000).
  - SYSRAM_WE = CPU_EN & !CPU_RW & RAM hit.
  - Read returns SYSRAM_Q.
- PRG:
  - Read returns PRGROM_Q.
  - Writes are ignored.
- PAD write: only a write to PAD_BASE loads PAD_STROBE <= CPU_DO[0]. Writes to other pad addresses are ignored, because that address space is owned by the APU.
- Per-pad shift register sr_i, PAD_BITS wide:
  - While PAD_STROBE=1, sr_i reloads from PAD_STATE every cycle.
  - While PAD_STROBE=0, sr_i holds its value except when it shifts (see PAD read).
- PAD read from pad i returns {OPEN_BUS[DATA_W-1:5], 4'b0, d}:
  - d = PAD_STATE[i*PAD_BITS] when PAD_STROBE=1.
  - d = sr_i[0] otherwise.
  - A completed read with PAD_STROBE=0 shifts sr_i right and fills the MSB with 1. After PAD_BITS reads, d is 1 for every further read.
- Unmapped read returns OPEN_BUS.
- During writes and idle cycles, BUS_OUT = CPU_DO.
- Open-bus latch: on every cycle with CPU_EN=1, OPEN_BUS <= BUS_OUT. This covers reads and writes.

## Timing
- BUS_OUT, SYSRAM_ADDR, SYSRAM_WE, PRGROM_ADDR and region decode are combinational with zero latency.
- The CPU holds ADDR for at least one cycle before CPU_EN, so synchronous memories receive their address early.
- PAD_STROBE, sr_i and OPEN_BUS update on the rising CLK edge that ends a CPU_EN cycle. Exception: sr_i reloads on every edge while PAD_STROBE=1.
- A strobe write of 1 followed by a write of 0: sr_i holds the PAD_STATE sampled at the edge that clears the strobe.
- A pad read in the same cycle as a strobe write is impossible, since both require CPU_EN with opposite CPU_RW.
- Reset (asynchronous, any time, including mid-sequence):
  - PAD_STROBE=0, every sr_i = all 1s, OPEN_BUS=0.
  - Combinational outputs follow their inputs.

## Structure
- Package nes_bus_pkg holds:
  - The region typedef enum {RGN_RAM, RGN_PAD, RGN_PRG, RGN_NONE}.
  - The default base constants.
  - The pad read-data bit positions.
- Sub-module nes_pad_shift holds one pad's shift register, read bit and shift/reload logic. The top instantiates NUM_PADS copies of it in a generate loop.

## Test plan
- Write $55 to $0123, then read $0923 -> SYSRAM_ADDR=$123 both times, SYSRAM_WE asserted only on the write, read returns SYSRAM_Q.
- PAD_STATE pad0=8'b1000_0101; write 1 then 0 to $4016; do 10 reads of $4016 -> bit0 sequence 1,0,1,0,0,0,0,1,1,1.
- With PAD_STROBE=1, toggle PAD_STATE bit0 and read $4016 repeatedly -> bit0 tracks live input with no shifting. Write $01 to $4017 -> PAD_STROBE unchanged.
- Read $8000 with PRGROM_Q=$A9 (OPEN_BUS becomes $A9), then read $5000 -> BUS_OUT=$A9. Read $4016 -> bits 7:5 = 3'b101, bits 4:1 = 0.
- Assert RESET_N=0 mid shift sequence (after 3 reads) -> PAD_STROBE=0, OPEN_BUS=0, next pad reads return 1 without reload.
- NUM_PADS=4, PAD_BITS=16 -> pad 3 at $4019 shifts 16 distinct bits, then 1s. Reads at $401A are unmapped.
